lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of WAIT cycles without mem_rvalid before an error.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the reset: synchronous, active-low.
REQ-004 in_valid  in  1  SHALL flag an access request from the EXU.
REQ-005 in_ready  out  1  SHALL be high exactly when the FSM is in IDLE.
REQ-006 in_op  in  3  SHALL carry funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU apply to loads only.
REQ-007 in_wen  in  1  SHALL select the access type: 1 = store, 0 = load.
REQ-008 in_addr, in_wdata  in  32 each  SHALL carry the byte address and the store data.
REQ-009 in_rd  in  5  SHALL carry the load destination register.
REQ-010 mem_valid  out  1 / mem_ready  in  1  SHALL form the memory request handshake.
REQ-011 mem_addr  out  32, mem_wen  out  1, mem_wdata  out  32, mem_wmask  out  4  SHALL carry the memory request fields.
REQ-012 mem_rvalid  in  1, mem_rdata  in  32  SHALL carry the load response.
REQ-013 wb_wen  out  1, wb_waddr  out  5, wb_wdata  out  32  SHALL drive the GPR write port.
REQ-014 done  out  1, err  out  1, err_cause  out  2  SHALL report completion and faults as one-cycle pulses.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, FIN, ERR.
REQ-016 Accept rule: in_valid & in_ready at edge N latches op, wen, addr, wdata and rd.
REQ-017 Legality check at acceptance, giving err_cause:
- illegal op (011, 110, 111, or a store with 1xx) -> ERR, cause 3;
- H/HU with addr[0]=1, or W with addr[1:0]!=0 -> ERR, cause 0 for a load, 1 for a store;
- otherwise -> REQ.
REQ-018 ERR SHALL last one cycle with err=1, with no memory access and no writeback, then return to IDLE.
REQ-019 In REQ, mem_valid=1 and mem_addr={addr[31:2],2'b00}; all mem_* fields stay stable until mem_ready=1.
REQ-020 Store lanes:
- SB: mem_wdata = wdata[7:0] << 8*addr[1:0]; mem_wmask = 0001 << addr[1:0];
- SH: mem_wdata = wdata[15:0] << 16*addr[1]; mem_wmask = 0011 << addr[1:0];
- SW: mem_wdata = wdata; mem_wmask = 1111.
REQ-021 For loads, mem_wen=0 and mem_wmask=0000.
REQ-022 After the store handshake -> FIN; after the load handshake -> WAIT.
REQ-023 mem_rvalid SHALL be ignored outside WAIT.
REQ-024 WAIT behaviour:
- the counter clears on WAIT entry and increments each cycle without mem_rvalid;
- mem_rvalid=1 -> FIN; the lane is selected by addr[1:0] (H uses addr[1]), then sign-extended (B/H) or zero-extended (BU/HU/W);
- the counter reaching TIMEOUT-1 with mem_rvalid=0 -> ERR, cause 2;
- mem_rvalid in the threshold cycle wins over timeout.
REQ-025 FIN SHALL last one cycle with done=1; for loads, wb_wen=1 with wb_waddr=rd and wb_wdata=the extracted value.
REQ-026 In FIN, wb_wen SHALL be suppressed when rd=0; done still pulses.
REQ-027 Latency with zero-wait memory (mem_ready=1, mem_rvalid the cycle after the handshake):
- accept at N; mem_valid at N+1;
- store: done at N+2;
- load: rvalid at N+2, done and wb at N+3.
REQ-028 A new request SHALL be accepted only in IDLE, so there is no back-to-back overlap.
REQ-029 wb_wen, done and err SHALL never be high outside FIN/ERR.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE and clear the counter and all registered state.
REQ-031 During and after reset, mem_valid=wb_wen=done=err=0, err_cause=0, and wb_wdata=mem_*=0.
REQ-032 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-033 Reset mid-transaction (REQ or WAIT) SHALL abandon the access:
- mem_valid drops at the next edge;
- no done, err or writeback for that access;
- a late mem_rvalid is ignored.

Verification
REQ-034 LB addr=0x80000003, mem_rdata=0x80FF_1234, rd=5 -> wb_wen pulse, wb_waddr=5, wb_wdata=0xFFFFFF80, done at N+3.
REQ-035 SH addr=0x80000102, wdata=0x0000BEEF -> mem_addr=0x80000100, mem_wdata=0xBEEF0000, mem_wmask=1100, done at N+2 with mem_ready=1.
REQ-036 LW addr=0x80000006 -> err pulse, err_cause=0, mem_valid never asserted, in_ready=1 next cycle.
REQ-037 LHU addr=0x10, rd=0, mem_rdata=0xABCD0000 with mem_ready held low 3 cycles -> mem fields stable through the stall, done pulses, wb_wen stays 0.
REQ-038 LW with no mem_rvalid, TIMEOUT=16 -> err with err_cause=2 exactly 16 cycles after WAIT entry; mem_rvalid in that cycle instead -> done, no err.
REQ-039 rst=0 while in WAIT, then mem_rvalid=1 -> no wb/done/err; in_ready=1 after release.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: accepts one EXU access at a time, checks legality, issues a single
// memory request, extracts/extends load data and reports done/err as one-cycle pulses.
module lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic        in_wen,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_wen,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_cause
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             wen_q, wen_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [4:0]       rd_q, rd_d;
    logic [1:0]       cause_q, cause_d;
    logic [31:0]      load_q, load_d;

    function automatic logic op_illegal(input logic [2:0] op, input logic wen);
        return (op == 3'b011) || (op == 3'b110) || (op == 3'b111) || (wen && op[2]);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] addr);
        return ((op[1:0] == 2'b01) && addr[0]) || ((op == 3'b010) && (addr != 2'b00));
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [1:0] addr,
                                                input logic [31:0] wdata);
        case (op[1:0])
            2'b00:   return {24'b0, wdata[7:0]} << {addr, 3'b000};
            2'b01:   return {16'b0, wdata[15:0]} << {addr[1], 4'b0000};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] addr);
        case (op[1:0])
            2'b00:   return 4'b0001 << addr;
            2'b01:   return 4'b0011 << addr;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] addr,
                                                 input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> {addr, 3'b000};
        b = shifted[7:0];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return rdata;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        cause_d = cause_q;
        load_d  = load_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    wen_d   = in_wen;
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    rd_d    = in_rd;
                    if (op_illegal(in_op, in_wen)) begin
                        cause_d = 2'd3;
                        state_d = S_ERR;
                    end else if (misaligned(in_op, in_addr[1:0])) begin
                        cause_d = {1'b0, in_wen};
                        state_d = S_ERR;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_d = wen_q ? S_FIN : S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // A response arriving in the threshold cycle still completes the load
                if (mem_rvalid) begin
                    load_d  = load_extract(op_q, addr_q[1:0], mem_rdata);
                    state_d = S_FIN;
                end else if (cnt_q == CNT_LAST) begin
                    cause_d = 2'd2;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            cause_q <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            cause_q <= cause_d;
            load_q  <= load_d;
        end
    end

    // Request fields are zero outside REQ and held from the latched access inside it
    assign in_ready  = (state_q == S_IDLE);
    assign mem_valid = (state_q == S_REQ);
    assign mem_addr  = mem_valid ? {addr_q[31:2], 2'b00} : 32'b0;
    assign mem_wen   = mem_valid & wen_q;
    assign mem_wdata = mem_wen ? store_lanes(op_q, addr_q[1:0], wdata_q) : 32'b0;
    assign mem_wmask = mem_wen ? store_mask(op_q, addr_q[1:0]) : 4'b0;

    assign done      = (state_q == S_FIN);
    assign err       = (state_q == S_ERR);
    assign err_cause = err ? cause_q : 2'b0;
    assign wb_wen    = done & ~wen_q & (rd_q != 5'd0);
    assign wb_waddr  = (done & ~wen_q) ? rd_q : 5'd0;
    assign wb_wdata  = (done & ~wen_q) ? load_q : 32'b0;

endmodule
